// File: rtl/start_reveal_vga_control_pkg.sv
// start_reveal_vga_control_pkg: shared FSM state encoding and wipe-mode constants
package start_reveal_vga_control_pkg;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_OPENING = 2'd1,
    S_OPEN    = 2'd2,
    S_CLOSING = 2'd3
  } state_t;

  localparam logic [1:0] WIPE_H    = 2'd0;
  localparam logic [1:0] WIPE_V    = 2'd1;
  localparam logic [1:0] WIPE_IRIS = 2'd2;

endpackage

// File: rtl/start_reveal_vga_control_reveal_window_fsm.sv
// reveal_window_fsm: open/close animation FSM with tick divider and half-extent register
module reveal_window_fsm
  import start_reveal_vga_control_pkg::*;
#(
  parameter int H_ACTIVE = 640,
  parameter int V_ACTIVE = 480,
  parameter int COORD_W  = 11,
  parameter int TICK_DIV = 250000,
  parameter int STEP     = 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               ready_sig,
  input  logic               open_req,
  input  logic               close_req,
  input  logic [1:0]         mode_sel,
  output logic [COORD_W-1:0] ext,
  output logic [1:0]         mode,
  output logic               busy,
  output logic               open_done,
  output logic               close_done
);

  localparam int CNT_W = TICK_DIV > 1 ? $clog2(TICK_DIV) : 1;

  state_t             state, state_n;
  logic [COORD_W-1:0] ext_n, ext_max;
  logic [COORD_W:0]   up;
  logic [1:0]         mode_n;
  logic [CNT_W-1:0]   cnt, cnt_n;
  logic               tick, open_done_n, close_done_n;

  assign busy    = state == S_OPENING || state == S_CLOSING;
  assign tick    = busy && ready_sig && cnt == CNT_W'(TICK_DIV - 1);
  assign ext_max = mode == WIPE_V ? COORD_W'(V_ACTIVE / 2) : COORD_W'(H_ACTIVE / 2);
  assign up      = {1'b0, ext} + (COORD_W + 1)'(STEP);

  // next state: close wins over open, a request beats a coincident tick, the counter restarts on any state change
  always_comb begin
    state_n      = state;
    ext_n        = ext;
    mode_n       = mode;
    open_done_n  = 1'b0;
    close_done_n = 1'b0;
    case (state)
      S_IDLE: begin
        if (open_req && !close_req) begin
          state_n = S_OPENING;
          mode_n  = mode_sel;
        end
      end
      S_OPENING: begin
        if (close_req) state_n = S_CLOSING;
        else if (tick) begin
          ext_n = up >= {1'b0, ext_max} ? ext_max : up[COORD_W-1:0];
          if (up >= {1'b0, ext_max}) begin
            state_n     = S_OPEN;
            open_done_n = 1'b1;
          end
        end
      end
      S_OPEN: begin
        if (close_req) state_n = S_CLOSING;
      end
      S_CLOSING: begin
        if (open_req && !close_req) state_n = S_OPENING;
        else if (tick) begin
          ext_n = ext > COORD_W'(STEP) ? ext - COORD_W'(STEP) : '0;
          if (ext <= COORD_W'(STEP)) begin
            state_n      = S_IDLE;
            close_done_n = 1'b1;
          end
        end
      end
      default: state_n = S_IDLE;
    endcase
    cnt_n = state_n != state ? '0 : (busy && ready_sig) ? (tick ? '0 : cnt + CNT_W'(1)) : cnt;
  end

  // animation state registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_IDLE;
      ext        <= '0;
      mode       <= WIPE_H;
      cnt        <= '0;
      open_done  <= 1'b0;
      close_done <= 1'b0;
    end else begin
      state      <= state_n;
      ext        <= ext_n;
      mode       <= mode_n;
      cnt        <= cnt_n;
      open_done  <= open_done_n;
      close_done <= close_done_n;
    end
  end

endmodule

// File: rtl/start_reveal_vga_control.sv
// start_reveal_vga_control: start-screen pixel pipeline gated by an animated reveal window
module start_reveal_vga_control
  import start_reveal_vga_control_pkg::*;
#(
  parameter int H_ACTIVE = 640,
  parameter int V_ACTIVE = 480,
  parameter int COORD_W  = 11,
  parameter int ADDR_W   = 19,
  parameter int COLOR_W  = 1,
  parameter int TICK_DIV = 250000,
  parameter int STEP     = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 ready_sig,
  input  logic                 gameready_sig,
  input  logic [COORD_W-1:0]   ready_col_addr_sig,
  input  logic [COORD_W-1:0]   ready_row_addr_sig,
  input  logic                 open_req,
  input  logic                 close_req,
  input  logic [1:0]           mode_sel,
  output logic [ADDR_W-1:0]    tetris_rom_addr,
  input  logic [3*COLOR_W-1:0] tetris_rom_data,
  output logic [COLOR_W-1:0]   ready_red_sig,
  output logic [COLOR_W-1:0]   ready_green_sig,
  output logic [COLOR_W-1:0]   ready_blue_sig,
  output logic                 busy,
  output logic                 open_done,
  output logic                 close_done
);

  localparam int CX = H_ACTIVE / 2;
  localparam int CY = V_ACTIVE / 2;
  localparam int W  = COORD_W + 1;

  logic [COORD_W-1:0] ext, col_d, row_d;
  logic [1:0]         mode;
  logic               in_area, in_d, rdy_d, h_ok, v_ok, win, show;

  reveal_window_fsm #(
    .H_ACTIVE(H_ACTIVE),
    .V_ACTIVE(V_ACTIVE),
    .COORD_W (COORD_W),
    .TICK_DIV(TICK_DIV),
    .STEP    (STEP)
  ) u_fsm (
    .clk       (clk),
    .rst       (rst),
    .ready_sig (ready_sig),
    .open_req  (open_req),
    .close_req (close_req),
    .mode_sel  (mode_sel),
    .ext       (ext),
    .mode      (mode),
    .busy      (busy),
    .open_done (open_done),
    .close_done(close_done)
  );

  assign in_area = ready_sig && ready_row_addr_sig < COORD_W'(V_ACTIVE) && ready_col_addr_sig < COORD_W'(H_ACTIVE);

  // stage 1: ROM address for visible pixels; coordinates and qualifiers ride along
  always_ff @(posedge clk) begin
    if (rst) begin
      tetris_rom_addr <= '0;
      col_d           <= '0;
      row_d           <= '0;
      in_d            <= 1'b0;
      rdy_d           <= 1'b0;
    end else begin
      if (in_area) tetris_rom_addr <= ADDR_W'(ready_row_addr_sig) * ADDR_W'(H_ACTIVE) + ADDR_W'(ready_col_addr_sig);
      col_d <= ready_col_addr_sig;
      row_d <= ready_row_addr_sig;
      in_d  <= in_area;
      rdy_d <= ready_sig;
    end
  end

  // window test rewritten as c+ext >= CX so the lower bound never underflows
  always_comb begin
    h_ok = {1'b0, col_d} + {1'b0, ext} >= W'(CX) && {1'b0, col_d} < W'(CX) + {1'b0, ext};
    v_ok = {1'b0, row_d} + {1'b0, ext} >= W'(CY) && {1'b0, row_d} < W'(CY) + {1'b0, ext};
    win  = mode == WIPE_V ? v_ok : mode == WIPE_IRIS ? h_ok && v_ok : h_ok;
    show = rdy_d && gameready_sig && in_d && win;
  end

  // stage 2: pass ROM colour through the window, black elsewhere
  always_ff @(posedge clk) begin
    if (rst) begin
      ready_red_sig   <= '0;
      ready_green_sig <= '0;
      ready_blue_sig  <= '0;
    end else begin
      ready_red_sig   <= show ? tetris_rom_data[COLOR_W-1:0] : '0;
      ready_green_sig <= show ? tetris_rom_data[2*COLOR_W-1:COLOR_W] : '0;
      ready_blue_sig  <= show ? tetris_rom_data[3*COLOR_W-1:2*COLOR_W] : '0;
    end
  end

endmodule

// File: tb/tb_start_reveal_vga_control.sv
// tb_start_reveal_vga_control: randomized stimulus against a behavioural reveal-window model
module tb_start_reveal_vga_control;

  localparam int H    = 640;
  localparam int V    = 480;
  localparam int CW   = 11;
  localparam int AW   = 19;
  localparam int COLW = 4;
  localparam int TD   = 4;
  localparam int ST   = 3;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            ready_sig = 1'b0;
  logic            gameready_sig = 1'b0;
  logic            open_req = 1'b0;
  logic            close_req = 1'b0;
  logic [1:0]      mode_sel = 2'd0;
  logic [CW-1:0]   col = '0;
  logic [CW-1:0]   row = '0;
  logic [AW-1:0]   rom_addr;
  logic [3*COLW-1:0] rom_data;
  logic [COLW-1:0] red, green, blue;
  logic            busy, open_done, close_done;

  int n_vec = 0;
  int n_err = 0;

  int m_st, m_ext, m_mode, m_cnt, m_addr, p_col, p_row;
  bit p_in, p_rdy, m_od, m_cd, m_valid;
  logic [11:0] m_rgb;

  int low_pct = 0;
  int gr_pct = 100;
  int want_mode = 0;
  bit corner = 0;
  int cr[6] = '{0, 479, 480, 479, 0, 240};
  int cc[6] = '{0, 639, 639, 640, 639, 320};

  always #5 clk = ~clk;

  start_reveal_vga_control #(
    .H_ACTIVE(H), .V_ACTIVE(V), .COORD_W(CW), .ADDR_W(AW),
    .COLOR_W(COLW), .TICK_DIV(TD), .STEP(ST)
  ) dut (
    .clk               (clk),
    .rst               (rst),
    .ready_sig         (ready_sig),
    .gameready_sig     (gameready_sig),
    .ready_col_addr_sig(col),
    .ready_row_addr_sig(row),
    .open_req          (open_req),
    .close_req         (close_req),
    .mode_sel          (mode_sel),
    .tetris_rom_addr   (rom_addr),
    .tetris_rom_data   (rom_data),
    .ready_red_sig     (red),
    .ready_green_sig   (green),
    .ready_blue_sig    (blue),
    .busy              (busy),
    .open_done         (open_done),
    .close_done        (close_done)
  );

  function automatic logic [11:0] rom_word(int a);
    logic [18:0] x;
    x = a[18:0];
    return x == 0 ? 12'hABC : x[11:0] ^ x[18:7] ^ 12'h5A3;
  endfunction

  assign rom_data = rom_word(int'(rom_addr));

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic bit in_win(int c, int r, int e, int md);
    bit h, v;
    h = (H / 2 - e <= c) && (c < H / 2 + e);
    v = (V / 2 - e <= r) && (r < V / 2 + e);
    return md == 1 ? v : md == 2 ? (h && v) : h;
  endfunction

  function automatic int pick(int ctr, int e, int lim);
    int v;
    case ($urandom_range(2))
      0:       v = int'($urandom_range(lim));
      1:       v = ctr - e + int'($urandom_range(4)) - 2;
      default: v = ctr + e + int'($urandom_range(4)) - 2;
    endcase
    return v < 0 ? 0 : v;
  endfunction

  task automatic model_step();
    int emax, nx, ne;
    bit show, tick, bz;
    if (rst) begin
      m_st = 0; m_ext = 0; m_mode = 0; m_cnt = 0; m_addr = 0;
      p_col = 0; p_row = 0; p_in = 0; p_rdy = 0; m_od = 0; m_cd = 0;
      m_rgb = '0; m_valid = 1;
      return;
    end
    show  = p_rdy && gameready_sig && p_in && in_win(p_col, p_row, m_ext, m_mode);
    m_rgb = show ? rom_word(m_addr) : 12'h0;
    p_in  = ready_sig && int'(row) < V && int'(col) < H;
    if (p_in) m_addr = int'(row) * H + int'(col);
    p_col = int'(col); p_row = int'(row); p_rdy = ready_sig;
    emax = m_mode == 1 ? V / 2 : H / 2;
    bz   = m_st == 1 || m_st == 3;
    tick = bz && ready_sig && m_cnt == TD - 1;
    nx = m_st; ne = m_ext; m_od = 0; m_cd = 0;
    if (m_st == 0 && open_req && !close_req) begin
      nx = 1; m_mode = int'(mode_sel);
    end else if ((m_st == 1 || m_st == 2) && close_req) nx = 3;
    else if (m_st == 3 && open_req && !close_req) nx = 1;
    else if (m_st == 1 && tick) begin
      ne = m_ext + ST > emax ? emax : m_ext + ST;
      if (ne == emax) begin nx = 2; m_od = 1; end
    end else if (m_st == 3 && tick) begin
      ne = m_ext < ST ? 0 : m_ext - ST;
      if (ne == 0) begin nx = 0; m_cd = 1; end
    end
    m_cnt = nx != m_st ? 0 : (bz && ready_sig) ? (tick ? 0 : m_cnt + 1) : m_cnt;
    m_st = nx; m_ext = ne;
  endtask

  task automatic cyc(input bit op = 0, input bit cl = 0, input bit rs = 0);
    int k;
    @(negedge clk);
    if (m_valid) begin
      check("rgb", {20'd0, blue, green, red}, {20'd0, m_rgb});
      check("addr", 32'(rom_addr), 32'(m_addr));
      check("busy", 32'(busy), 32'(m_st == 1 || m_st == 3));
      check("open_done", 32'(open_done), 32'(m_od));
      check("close_done", 32'(close_done), 32'(m_cd));
    end
    rst = rs;
    open_req = op;
    close_req = cl;
    mode_sel = op ? 2'(want_mode) : 2'($urandom);
    ready_sig = $urandom_range(99) >= low_pct;
    gameready_sig = $urandom_range(99) < gr_pct;
    if (corner) begin
      k = int'($urandom_range(5));
      row = CW'(cr[k]);
      col = CW'(cc[k]);
    end else begin
      col = CW'(pick(H / 2, m_ext, 700));
      row = CW'(pick(V / 2, m_ext, 520));
    end
    model_step();
  endtask

  task automatic wait_st(input int s, input int lim);
    int n = 0;
    while (m_st != s && n < lim) begin
      cyc();
      n++;
    end
    if (m_st != s) check("wait_state", 32'(m_st), 32'(s));
  endtask

  initial begin
    repeat (3) cyc(0, 0, 1);
    for (int m = 0; m < 4; m++) begin
      want_mode = m;
      low_pct = 20;
      cyc(1, 0, 0);
      wait_st(2, 3000);
      corner = 1;
      repeat (12) cyc();
      corner = 0;
      repeat (20) cyc();
      if (m == 2) begin
        gr_pct = 0;
        repeat (30) cyc();
        gr_pct = 100;
      end
      cyc(0, 1, 0);
      wait_st(0, 3000);
    end
    low_pct = 0;
    want_mode = 0;
    cyc(1, 0, 0);
    repeat (400) cyc();
    cyc(0, 1, 0);
    repeat (200) cyc();
    want_mode = 1;
    cyc(1, 0, 0);
    repeat (120) cyc();
    cyc(1, 1, 0);
    wait_st(0, 3000);
    want_mode = 0;
    cyc(1, 0, 0);
    repeat (50) cyc();
    low_pct = 100;
    repeat (1000) cyc();
    low_pct = 0;
    wait_st(2, 3000);
    cyc(0, 1, 0);
    repeat (37) cyc();
    cyc(0, 0, 1);
    repeat (5) cyc();
    low_pct = 20;
    gr_pct = 90;
    repeat (4000) begin
      want_mode = int'($urandom_range(3));
      cyc($urandom_range(99) < 2, $urandom_range(99) < 2, $urandom_range(999) == 0);
    end
    repeat (2) cyc();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
